// File: rtl/reg_file_pkg.sv
// Shared constants and types for the LC-3 register file with scoreboard.
package reg_file_pkg;

  localparam int unsigned LC3_WIDTH  = 16;
  localparam int unsigned LC3_ADDR_W = 3;

  typedef logic [LC3_ADDR_W-1:0] addr_t;
  typedef logic [LC3_WIDTH-1:0]  word_t;

endpackage

// File: rtl/decoder_onehot.sv
// Enable-gated binary to one-hot decoder: out = en ? (1 << in) : 0.
module decoder_onehot #(
  parameter int unsigned N = 3
) (
  input  logic            en_i,
  input  logic [N-1:0]    in_i,
  output logic [2**N-1:0] out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[in_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// LC-3 register file with per-register pending (scoreboard) bits.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH  = LC3_WIDTH,
  parameter int unsigned ADDR_W = LC3_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_reg_i,
  input  logic [ADDR_W-1:0] dr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              reserve_i,
  input  logic [ADDR_W-1:0] reserve_dr_i,
  input  logic [ADDR_W-1:0] sr1_i,
  input  logic [ADDR_W-1:0] sr2_i,
  output logic [WIDTH-1:0]  sr1_out_o,
  output logic [WIDTH-1:0]  sr2_out_o,
  output logic              sr1_pend_o,
  output logic              sr2_pend_o,
  output logic              any_pend_o
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [WIDTH-1:0] regs_q [Depth];
  logic [WIDTH-1:0] regs_d [Depth];
  logic [Depth-1:0] pend_q, pend_d;
  logic [Depth-1:0] wr_en;
  logic [Depth-1:0] rsv_mask;

  decoder_onehot #(
    .N(ADDR_W)
  ) u_wr_dec (
    .en_i (ld_reg_i),
    .in_i (dr_i),
    .out_o(wr_en)
  );

  decoder_onehot #(
    .N(ADDR_W)
  ) u_rsv_dec (
    .en_i (reserve_i),
    .in_i (reserve_dr_i),
    .out_o(rsv_mask)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < Depth; i++) begin
      if (wr_en[i]) begin
        regs_d[i] = wdata_i;
      end
    end
    // Reserve applied after the clear so a same-register issue wins over retirement.
    pend_d = (pend_q & ~wr_en) | rsv_mask;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign any_pend_o = |pend_q;

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    sr1_out_o  = regs_q[sr1_i];
    sr1_pend_o = pend_q[sr1_i];
    if (ld_reg_i && (dr_i == sr1_i)) begin
      sr1_out_o  = wdata_i;
      sr1_pend_o = reserve_i && (reserve_dr_i == sr1_i);
    end
  end

  always_comb begin
    sr2_out_o  = regs_q[sr2_i];
    sr2_pend_o = pend_q[sr2_i];
    if (ld_reg_i && (dr_i == sr2_i)) begin
      sr2_out_o  = wdata_i;
      sr2_pend_o = reserve_i && (reserve_dr_i == sr2_i);
    end
  end
`else
  assign sr1_out_o  = regs_q[sr1_i];
  assign sr2_out_o  = regs_q[sr2_i];
  assign sr1_pend_o = pend_q[sr1_i];
  assign sr2_pend_o = pend_q[sr2_i];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised self-checking bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int unsigned Depth = 2**LC3_ADDR_W;

  logic  clk = 1'b0;
  logic  reset, ld_reg, reserve;
  addr_t dr, reserve_dr, sr1, sr2;
  word_t wdata;
  word_t sr1_out, sr2_out;
  logic  sr1_pend, sr2_pend, any_pend;

  word_t m_reg  [Depth];
  logic  m_pend [Depth];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  reg_file_sb #(
    .WIDTH (LC3_WIDTH),
    .ADDR_W(LC3_ADDR_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ld_reg_i    (ld_reg),
    .dr_i        (dr),
    .wdata_i     (wdata),
    .reserve_i   (reserve),
    .reserve_dr_i(reserve_dr),
    .sr1_i       (sr1),
    .sr2_i       (sr2),
    .sr1_out_o   (sr1_out),
    .sr2_out_o   (sr2_out),
    .sr1_pend_o  (sr1_pend),
    .sr2_pend_o  (sr2_pend),
    .any_pend_o  (any_pend)
  );

  function automatic word_t exp_out(addr_t a);
    word_t v = m_reg[a];
`ifdef REG_FILE_BYPASS_EN
    if (ld_reg && dr == a) v = wdata;
`endif
    return v;
  endfunction

  function automatic logic exp_pend(addr_t a);
    logic p = m_pend[a];
`ifdef REG_FILE_BYPASS_EN
    if (ld_reg && dr == a) p = reserve && (reserve_dr == a);
`endif
    return p;
  endfunction

  function automatic logic exp_any();
    logic p = 1'b0;
    for (int i = 0; i < Depth; i++) p |= m_pend[i];
    return p;
  endfunction

  task automatic idle();
    reset = 1'b0; ld_reg = 1'b0; reserve = 1'b0;
    dr = '0; reserve_dr = '0; wdata = '0; sr1 = '0; sr2 = '0;
  endtask

  // Update the model from the inputs present at the coming edge, then cross it.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        m_reg[i] = '0; m_pend[i] = 1'b0;
      end
    end else begin
      if (ld_reg) begin
        m_reg[dr] = wdata; m_pend[dr] = 1'b0;
      end
      if (reserve) m_pend[reserve_dr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; ld_reg = 1'b1; dr = 3'd2; wdata = 16'h1111;
    reserve = 1'b1; reserve_dr = 3'd2;
    tick();
    idle();
    for (int a = 0; a < Depth; a++) begin
      sr1 = addr_t'(a); sr2 = addr_t'(Depth - 1 - a); #1;
      checks++;
      if (sr1_out !== 16'h0000 || sr2_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_out a=%0d got sr1=%h sr2=%h exp 0000", a, sr1_out, sr2_out);
      end
      checks++;
      if (sr1_pend !== 1'b0 || sr2_pend !== 1'b0 || any_pend !== 1'b0) begin
        errors++;
        $display("FAIL reset_pend a=%0d got %b%b any=%b exp 0", a, sr1_pend, sr2_pend, any_pend);
      end
    end
  endtask

  task automatic test_write_readback();
    idle(); ld_reg = 1'b1; dr = 3'd3; wdata = 16'hBEEF;
    tick();
    idle(); sr1 = 3'd3; sr2 = 3'd4; #1;
    checks++;
    if (sr1_out !== 16'hBEEF || sr2_out !== 16'h0000) begin
      errors++;
      $display("FAIL write_readback got sr1=%h sr2=%h exp BEEF 0000", sr1_out, sr2_out);
    end
    for (int a = 0; a < Depth; a++) begin
      sr1 = addr_t'(a); #1;
      checks++;
      if (sr1_out !== m_reg[a]) begin
        errors++;
        $display("FAIL write_others a=%0d got=%h exp=%h", a, sr1_out, m_reg[a]);
      end
    end
    // ld_reg low must not write even with dr/wdata driven.
    idle(); dr = 3'd3; wdata = 16'hDEAD; tick();
    sr1 = 3'd3; #1;
    checks++;
    if (sr1_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL no_write got=%h exp=BEEF", sr1_out);
    end
  endtask

  task automatic test_scoreboard();
    idle(); reserve = 1'b1; reserve_dr = 3'd5; tick();
    idle(); sr1 = 3'd5; #1;
    checks++;
    if (sr1_pend !== 1'b1 || any_pend !== 1'b1) begin
      errors++;
      $display("FAIL sb_reserve got pend=%b any=%b exp 1 1", sr1_pend, any_pend);
    end
    reserve = 1'b1; reserve_dr = 3'd5; tick();  // re-reserve: no counting
    idle(); ld_reg = 1'b1; dr = 3'd5; wdata = 16'h1234; tick();
    idle(); sr1 = 3'd5; #1;
    checks++;
    if (sr1_pend !== 1'b0 || sr1_out !== 16'h1234 || any_pend !== 1'b0) begin
      errors++;
      $display("FAIL sb_release got pend=%b out=%h any=%b exp 0 1234 0",
               sr1_pend, sr1_out, any_pend);
    end
    // Reserve 1 while writing 6 in the same cycle: both take effect.
    idle(); reserve = 1'b1; reserve_dr = 3'd6; tick();
    idle(); reserve = 1'b1; reserve_dr = 3'd1; ld_reg = 1'b1; dr = 3'd6; wdata = 16'h0606; tick();
    idle(); sr1 = 3'd1; sr2 = 3'd6; #1;
    checks++;
    if (sr1_pend !== 1'b1 || sr2_pend !== 1'b0 || sr2_out !== 16'h0606) begin
      errors++;
      $display("FAIL sb_diff got p1=%b p6=%b out6=%h exp 1 0 0606", sr1_pend, sr2_pend, sr2_out);
    end
  endtask

  task automatic test_same_reg();
    idle(); reserve = 1'b1; reserve_dr = 3'd2; tick();
    idle(); ld_reg = 1'b1; dr = 3'd2; wdata = 16'hC0DE; reserve = 1'b1; reserve_dr = 3'd2;
    tick();
    idle(); sr1 = 3'd2; sr2 = 3'd2; #1;
    checks++;
    if (sr1_pend !== 1'b1 || sr2_pend !== 1'b1 || sr1_out !== 16'hC0DE || sr2_out !== 16'hC0DE)
    begin
      errors++;
      $display("FAIL same_reg got pend=%b%b out=%h/%h exp 11 C0DE", sr1_pend, sr2_pend,
               sr1_out, sr2_out);
    end
  endtask

  task automatic test_reset_mid();
    idle(); reserve = 1'b1; reserve_dr = 3'd1; tick();
    idle(); reserve = 1'b1; reserve_dr = 3'd6; ld_reg = 1'b1; dr = 3'd7; wdata = 16'h00FF; tick();
    idle(); reset = 1'b1; ld_reg = 1'b1; dr = 3'd0; wdata = 16'hAAAA;
    reserve = 1'b1; reserve_dr = 3'd3;
    tick();
    idle();
    checks++;
    if (any_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_any got=%b exp=0", any_pend);
    end
    for (int a = 0; a < Depth; a++) begin
      sr1 = addr_t'(a); #1;
      checks++;
      if (sr1_out !== 16'h0000 || sr1_pend !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid a=%0d got out=%h pend=%b exp 0000 0", a, sr1_out, sr1_pend);
      end
    end
  endtask

  task automatic test_bypass();
    word_t exp_same;
    logic  exp_p;
    idle(); ld_reg = 1'b1; dr = 3'd4; wdata = 16'h0404; reserve = 1'b1; reserve_dr = 3'd4; tick();
    idle(); ld_reg = 1'b1; dr = 3'd4; wdata = 16'h5A5A; sr1 = 3'd4; #1;
`ifdef REG_FILE_BYPASS_EN
    exp_same = 16'h5A5A; exp_p = 1'b0;
`else
    exp_same = 16'h0404; exp_p = 1'b1;
`endif
    checks++;
    if (sr1_out !== exp_same || sr1_pend !== exp_p || any_pend !== 1'b1) begin
      errors++;
      $display("FAIL bypass_same got out=%h pend=%b any=%b exp %h %b 1", sr1_out, sr1_pend,
               any_pend, exp_same, exp_p);
    end
    tick();
    idle(); sr1 = 3'd4; #1;
    checks++;
    if (sr1_out !== 16'h5A5A || sr1_pend !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after got out=%h pend=%b exp 5A5A 0", sr1_out, sr1_pend);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 29) == 0);
      ld_reg     = $urandom_range(0, 1) == 1;
      reserve    = $urandom_range(0, 2) == 0;
      dr         = addr_t'($urandom);
      reserve_dr = ($urandom_range(0, 3) == 0) ? dr : addr_t'($urandom);
      wdata      = word_t'($urandom);
      sr1        = addr_t'($urandom);
      sr2        = ($urandom_range(0, 4) == 0) ? sr1 : addr_t'($urandom);
      #1;
      checks++;
      if (sr1_out !== exp_out(sr1) || sr2_out !== exp_out(sr2)) begin
        errors++;
        $display("FAIL rand_out n=%0d got %h/%h exp %h/%h", n, sr1_out, sr2_out,
                 exp_out(sr1), exp_out(sr2));
      end
      checks++;
      if (sr1_pend !== exp_pend(sr1) || sr2_pend !== exp_pend(sr2) || any_pend !== exp_any())
      begin
        errors++;
        $display("FAIL rand_pend n=%0d got %b%b any=%b exp %b%b any=%b", n, sr1_pend, sr2_pend,
                 any_pend, exp_pend(sr1), exp_pend(sr2), exp_any());
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) begin
      m_reg[i] = '0; m_pend[i] = 1'b0;
    end
    idle();
    test_reset();
    test_write_readback();
    test_scoreboard();
    test_same_reg();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised LC-3 general-purpose register file: DEPTH = 2**ADDR_W registers of WIDTH bits.
- One write port and two combinational read ports.
- Per-register pending (scoreboard) bit, so a pipelined datapath can stall on outstanding writes.
- Successor to the fixed 8-register file; the write select comes from a parametrised one-hot decoder.

Parameters:
- WIDTH, 16, data width of each register
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ld_reg  input  1  write enable
- dr  input  ADDR_W  write (destination) register address
- wdata  input  WIDTH  write data
- reserve  input  1  mark register reserve_dr pending
- reserve_dr  input  ADDR_W  register to reserve
- sr1  input  ADDR_W  read port 1 address
- sr2  input  ADDR_W  read port 2 address
- sr1_out  output  WIDTH  read port 1 data
- sr2_out  output  WIDTH  read port 2 data
- sr1_pend  output  1  pending bit of register sr1
- sr2_pend  output  1  pending bit of register sr2
- any_pend  output  1  OR of all pending bits (registered state)

Behaviour:
- Clock and reset: single clock domain. Synchronous, active-high reset; reset is sampled only on the rising edge of clk.
- Reset:
  - All registers clear to 0 and all pending bits clear to 0 on the edge where reset=1.
  - Outputs after that edge: sr*_out=0, sr*_pend=0, any_pend=0.
  - Reset overrides ld_reg and reserve in the same cycle.
  - Reset asserted mid-operation discards any in-flight reservation.
- Write:
  - On a rising edge with ld_reg=1, reg[dr] <= wdata.
  - The write enable is the one-hot decode of dr, gated by ld_reg. Exactly one register is written; all others hold.
  - ld_reg=0 writes nothing, regardless of dr.
- Read:
  - sr1_out and sr2_out are combinational from the register array; zero-cycle latency after the address changes.
  - A write becomes visible on the read ports the cycle after the edge (no bypass, see Optional Feature).
  - sr1 == sr2 is legal; both ports return the same data.
- Scoreboard:
  - pend[reserve_dr] <= 1 on an edge with reserve=1.
  - pend[dr] <= 0 on an edge with ld_reg=1.
  - Reserve and write of the same register in the same cycle: reserve wins, so pend stays or becomes 1. This models a new instruction issuing as an older one retires.
  - Reserve and write of different registers in the same cycle: both take effect.
  - Reserving an already-pending register: no change (bit stays 1; no counting).
  - Writing a non-pending register: pend stays 0, and the data write still occurs.
- Pending outputs: sr*_pend = pend[sr*] (combinational from registered state); any_pend = |pend.
- Width rules: addresses are unsigned with no out-of-range case, since DEPTH = 2**ADDR_W exactly. wdata is stored unmodified, with no sign handling.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If ld_reg=1 and dr==sr1, then sr1_out=wdata and sr1_pend=0 in that same cycle; likewise for port 2.
  - Exception: if reserve=1 and reserve_dr equals that port's address in the same cycle, sr*_pend=1.
  - any_pend is unaffected by bypass.
- Undefined: no forwarding. Reads and pend outputs reflect registered state only; new data and cleared pend are seen one cycle after the write edge.

Decomposition:
- Shared package reg_file_pkg:
  - constants LC3_WIDTH=16 and LC3_ADDR_W=3;
  - typedefs for the register address (ADDR_W bits) and data word (WIDTH bits).
- Sub-module decoder_onehot:
  - parameter N (input bits);
  - combinational;
  - en input, in[N-1:0], out[2**N-1:0];
  - out = en ? (1<<in) : 0.
  - Instantiated once for the write enable and once for the reserve mask.
- Top level holds the register array, the pend vector and the read muxes.

Test Plan:
- Reset then read: assert reset for 1 cycle, then sweep sr1/sr2 over 0..7 -> all sr*_out=0x0000, sr*_pend=0, any_pend=0.
- Write/readback: ld_reg=1, dr=3, wdata=0xBEEF for one edge; then sr1=3, sr2=4 -> sr1_out=0xBEEF, sr2_out=0x0000, and no other register changed.
- Scoreboard basic: reserve=1, reserve_dr=5 for one edge -> sr1_pend=1 when sr1=5, any_pend=1; then ld_reg=1, dr=5, wdata=0x1234 for one edge -> sr1_pend=0, sr1_out=0x1234, any_pend=0.
- Simultaneous reserve and write of the same register: with pend[2]=1, drive ld_reg=1, dr=2, reserve=1, reserve_dr=2 for one edge -> pend[2] stays 1, reg[2]=wdata.
- Reset mid-operation: reserve registers 1, 6 and write reg[7]=0x00FF; assert reset together with ld_reg=1, dr=0, wdata=0xAAAA -> all registers 0 (including reg[0]), all pend 0.
- Bypass (REG_FILE_BYPASS_EN defined): with pend[4]=1, drive ld_reg=1, dr=4, wdata=0x5A5A, sr1=4 -> same cycle sr1_out=0x5A5A, sr1_pend=0. Without the macro -> sr1_out holds the old value and sr1_pend=1 until after the edge.
